// File: rtl/fg_pkg.sv
// Shared definitions for the fg_timebase slice: timebase state encoding and
// the operating-mode constants sampled when a run or burst starts.
package fg_pkg;

  typedef logic [1:0] fg_state_t;

  localparam fg_state_t STOP  = 2'd0;
  localparam fg_state_t ARMED = 2'd1;
  localparam fg_state_t RUN   = 2'd2;

  localparam logic MODE_CONT  = 1'b0;
  localparam logic MODE_BURST = 1'b1;

endpackage

// File: rtl/fg_prescaler.sv
// Clock-enable prescaler: counts clocks while running and emits a one-cycle
// tick every prescaler_q_i+1 clocks. The count is held at zero whenever the
// timebase is not running, so every run starts a fresh prescaler interval.
module fg_prescaler #(
  parameter int PRESCALER_BITWIDTH = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          run_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_q_i,
  output logic                          tick_o
);

  logic [PRESCALER_BITWIDTH-1:0] ps_q, ps_d;

  assign tick_o = run_i & (ps_q == prescaler_q_i);

  // Next prescaler count: clear on tick or when idle, otherwise advance.
  always_comb begin
    ps_d = ps_q;
    if (!run_i || tick_o) begin
      ps_d = '0;
    end else begin
      ps_d = ps_q + PRESCALER_BITWIDTH'(1);
    end
  end

  // Prescaler count register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

endmodule

// File: rtl/fg_timebase.sv
// Timebase feeding the waveform generator: STOP/ARMED/RUN control FSM,
// shadowed configuration, period counter (CR) and burst period counter.
// Optional build macro FG_TRIG_SYNC_EN adds a 2-flop synchroniser on
// trigger_i ahead of edge detection (two extra cycles of trigger latency).
module fg_timebase
  import fg_pkg::*;
#(
  parameter int COUNTER_BITWIDTH   = 32,
  parameter int PRESCALER_BITWIDTH = 16,
  parameter int BURST_BITWIDTH     = 8
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          enable_i,
  input  logic                          mode_i,
  input  logic                          trigger_i,
  input  logic [PRESCALER_BITWIDTH-1:0] prescaler_i,
  input  logic [COUNTER_BITWIDTH-1:0]   counter_i,
  input  logic [BURST_BITWIDTH-1:0]     burst_count_i,
  output logic                          clk_en_o,
  output logic [COUNTER_BITWIDTH-1:0]   CR_o,
  output logic                          period_done_o,
  output logic                          busy_o
);

  fg_state_t                     state_q, state_d;
  logic [PRESCALER_BITWIDTH-1:0] prescaler_q;
  logic [COUNTER_BITWIDTH-1:0]   counter_q;
  logic [BURST_BITWIDTH-1:0]     burst_q;
  logic                          mode_q;
  logic [COUNTER_BITWIDTH-1:0]   cr_q, cr_d;
  logic                          trig_s, trig_d_q, trig_edge;
  logic                          tick, wrap, burst_last, load_shadow;

`ifdef FG_TRIG_SYNC_EN
  logic [1:0] trig_sync_q;

  // Two-flop synchroniser so an asynchronous trigger can be used safely.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      trig_sync_q <= 2'b00;
    end else begin
      trig_sync_q <= {trig_sync_q[0], trigger_i};
    end
  end

  assign trig_s = trig_sync_q[1];
`else
  assign trig_s = trigger_i;
`endif

  // Delayed trigger copy for rising-edge detection.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      trig_d_q <= 1'b0;
    end else begin
      trig_d_q <= trig_s;
    end
  end

  assign trig_edge = trig_s & ~trig_d_q;

  // Dropping enable_i suppresses the tick in the same cycle.
  fg_prescaler #(
    .PRESCALER_BITWIDTH(PRESCALER_BITWIDTH)
  ) u_prescaler (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .run_i        ((state_q == RUN) & enable_i),
    .prescaler_q_i(prescaler_q),
    .tick_o       (tick)
  );

  assign wrap       = tick & (cr_q == counter_q);
  assign burst_last = wrap & (mode_q == MODE_BURST) & (burst_q == BURST_BITWIDTH'(1));

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= STOP;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; losing enable overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = STOP;
    end else begin
      case (state_q)
        STOP:    state_d = (mode_i == MODE_BURST) ? ARMED : RUN;
        ARMED:   if (trig_edge) state_d = RUN;
        RUN:     if (burst_last) state_d = ARMED;
        default: state_d = STOP;
      endcase
    end
  end

  // FSM outputs: busy flag and shadow capture when leaving STOP or ARMED.
  always_comb begin
    busy_o      = (state_q == RUN);
    load_shadow = (state_q != RUN) && (state_d != STOP) && (state_d != state_q);
  end

  // Shadow configuration; period settings only change at period boundaries.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      prescaler_q <= '0;
      counter_q   <= '0;
      burst_q     <= '0;
      mode_q      <= MODE_CONT;
    end else if (load_shadow) begin
      prescaler_q <= prescaler_i;
      counter_q   <= counter_i;
      mode_q      <= mode_i;
      burst_q     <= (burst_count_i == '0) ? BURST_BITWIDTH'(1) : burst_count_i;
    end else if (wrap) begin
      prescaler_q <= prescaler_i;
      counter_q   <= counter_i;
      if (mode_q == MODE_BURST) begin
        burst_q <= burst_q - BURST_BITWIDTH'(1);
      end
    end
  end

  // Next CR value: zero outside RUN, otherwise advance and wrap on ticks.
  always_comb begin
    cr_d = cr_q;
    if (state_d != RUN) begin
      cr_d = '0;
    end else if (tick) begin
      cr_d = wrap ? '0 : cr_q + COUNTER_BITWIDTH'(1);
    end
  end

  // Period counter register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cr_q <= '0;
    end else begin
      cr_q <= cr_d;
    end
  end

  assign clk_en_o      = tick;
  assign period_done_o = wrap;
  assign CR_o          = cr_q;

endmodule

// File: tb/tb_fg_timebase.sv
// Self-checking bench for fg_timebase: directed scenarios plus randomized
// stimulus, all compared every cycle against a behavioural model.
module tb_fg_timebase;

  localparam int CW = 32;
  localparam int PW = 16;
  localparam int BW = 8;

  logic          clk_i = 1'b0;
  logic          rstn_i = 1'b1;
  logic          enable_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          trigger_i = 1'b0;
  logic [PW-1:0] prescaler_i = '0;
  logic [CW-1:0] counter_i = '0;
  logic [BW-1:0] burst_count_i = '0;
  logic          clk_en_o;
  logic [CW-1:0] CR_o;
  logic          period_done_o;
  logic          busy_o;

  always #5 clk_i = ~clk_i;

  fg_timebase #(
    .COUNTER_BITWIDTH  (CW),
    .PRESCALER_BITWIDTH(PW),
    .BURST_BITWIDTH    (BW)
  ) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .enable_i     (enable_i),
    .mode_i       (mode_i),
    .trigger_i    (trigger_i),
    .prescaler_i  (prescaler_i),
    .counter_i    (counter_i),
    .burst_count_i(burst_count_i),
    .clk_en_o     (clk_en_o),
    .CR_o         (CR_o),
    .period_done_o(period_done_o),
    .busy_o       (busy_o)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_cnt = 0;

  // Behavioural model: 0 = stopped, 1 = waiting for trigger, 2 = running.
  int          m_state;
  longint      m_ps, m_pre, m_cr, m_cnt, m_rem;
  bit          m_burst, m_prev, m_s0, m_s1;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_ps = 0; m_pre = 0; m_cr = 0; m_cnt = 0; m_rem = 0;
    m_burst = 0; m_prev = 0; m_s0 = 0; m_s1 = 0;
  endtask

  task automatic model_start();
    m_pre   = prescaler_i;
    m_cnt   = counter_i;
    m_burst = mode_i;
    m_rem   = (burst_count_i == 0) ? 1 : burst_count_i;
  endtask

  // Advance the model by one clock using the inputs seen at that edge.
  task automatic model_step();
    bit trig_now, rise, tk;
`ifdef FG_TRIG_SYNC_EN
    trig_now = m_s1;
    m_s1 = m_s0;
    m_s0 = trigger_i;
`else
    trig_now = trigger_i;
`endif
    rise   = trig_now && !m_prev;
    m_prev = trig_now;
    tk     = (m_state == 2) && enable_i && (m_ps == m_pre);
    if (!enable_i) begin
      m_state = 0; m_cr = 0; m_ps = 0;
    end else if (m_state == 0) begin
      model_start();
      m_state = mode_i ? 1 : 2;
    end else if (m_state == 1) begin
      if (rise) begin
        model_start();
        m_state = 2;
      end
    end else if (tk) begin
      m_ps = 0;
      if (m_cr == m_cnt) begin
        m_cr  = 0;
        m_pre = prescaler_i;
        m_cnt = counter_i;
        if (m_burst) begin
          if (m_rem == 1) m_state = 1;
          m_rem = m_rem - 1;
        end
      end else begin
        m_cr = m_cr + 1;
      end
    end else begin
      m_ps = m_ps + 1;
    end
  endtask

  // Compare outputs mid-cycle, then follow the DUT across the clock edge.
  task automatic run_cycles(input int n);
    bit e_tick;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      e_tick = (m_state == 2) && enable_i && (m_ps == m_pre);
      check_eq("clk_en", 64'(clk_en_o), 64'(e_tick));
      check_eq("CR", 64'(CR_o), 64'(m_cr));
      check_eq("period_done", 64'(period_done_o), 64'(e_tick && (m_cr == m_cnt)));
      check_eq("busy", 64'(busy_o), 64'(m_state == 2));
      if (clk_en_o) tick_cnt++;
      @(posedge clk_i);
      model_step();
      #1;
    end
  endtask

  task automatic pulse_trigger();
    trigger_i = 1'b1;
    run_cycles(1);
    trigger_i = 1'b0;
  endtask

  initial begin
    model_reset();
    #2 rstn_i = 1'b0;
    #20;
    check_eq("rst_clk_en", 64'(clk_en_o), 64'd0);
    check_eq("rst_CR", 64'(CR_o), 64'd0);
    check_eq("rst_period_done", 64'(period_done_o), 64'd0);
    check_eq("rst_busy", 64'(busy_o), 64'd0);
    @(posedge clk_i);
    #1 rstn_i = 1'b1;

    // Continuous, tick every clock, period of 4.
    mode_i = 1'b0; prescaler_i = 0; counter_i = 3;
    run_cycles(5);
    enable_i = 1'b1;
    tick_cnt = 0;
    run_cycles(16);
    check_eq("cont_ticks", 64'(tick_cnt), 64'd15);

    // Divide by 5, CR toggling 0/1.
    enable_i = 1'b0;
    run_cycles(2);
    prescaler_i = 4; counter_i = 1; enable_i = 1'b1;
    tick_cnt = 0;
    run_cycles(26);
    check_eq("div5_ticks", 64'(tick_cnt), 64'd5);

    // Period length changed mid-period only applies after the wrap.
    enable_i = 1'b0;
    run_cycles(2);
    prescaler_i = 0; counter_i = 5; enable_i = 1'b1;
    for (int i = 0; i < 20 && CR_o != 3; i++) run_cycles(1);
    check_eq("wait_cr3", 64'(CR_o), 64'd3);
    counter_i = 2;
    run_cycles(20);

    // Enable dropped mid-period.
    prescaler_i = 1; counter_i = 4;
    run_cycles(7);
    enable_i = 1'b0;
    tick_cnt = 0;
    run_cycles(5);
    check_eq("stop_ticks", 64'(tick_cnt), 64'd0);

    // Burst of 2 periods of 3 ticks, with an ignored mid-burst trigger.
    mode_i = 1'b1; burst_count_i = 2; counter_i = 2; prescaler_i = 0;
    enable_i = 1'b1;
    run_cycles(3);
    tick_cnt = 0;
    pulse_trigger();
    run_cycles(3);
    pulse_trigger();
    run_cycles(15);
    check_eq("burst1_ticks", 64'(tick_cnt), 64'd6);
    tick_cnt = 0;
    pulse_trigger();
    run_cycles(16);
    check_eq("burst2_ticks", 64'(tick_cnt), 64'd6);

    // Asynchronous reset in the middle of a burst.
    pulse_trigger();
    run_cycles(3);
    #3 rstn_i = 1'b0;
    #1;
    check_eq("arst_clk_en", 64'(clk_en_o), 64'd0);
    check_eq("arst_CR", 64'(CR_o), 64'd0);
    check_eq("arst_busy", 64'(busy_o), 64'd0);
    model_reset();
    @(posedge clk_i);
    #1 rstn_i = 1'b1;
    tick_cnt = 0;
    run_cycles(10);
    check_eq("arst_ticks", 64'(tick_cnt), 64'd0);

    // Burst count of zero runs a single period.
    burst_count_i = 0; counter_i = 3;
    tick_cnt = 0;
    pulse_trigger();
    run_cycles(14);
    check_eq("burst0_ticks", 64'(tick_cnt), 64'd4);

    // Randomized operation.
    for (int i = 0; i < 800; i++) begin
      enable_i  = ($urandom_range(0, 24) != 0);
      trigger_i = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 15) == 0) mode_i = ~mode_i;
      if ($urandom_range(0, 7) == 0) begin
        prescaler_i   = PW'($urandom_range(0, 3));
        counter_i     = CW'($urandom_range(0, 5));
        burst_count_i = BW'($urandom_range(0, 3));
      end
      run_cycles(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
